// File: rtl/microwave_cook_timer.sv
// BCD MM:SS cook-time countdown driven by the start-button controller's start/idle levels.
// Optional +30 s button logic is built only when MWV_ADD30_EN is defined.
module microwave_cook_timer #(
    parameter int TICK_DIV = 100_000_000,
    parameter int MAX_MIN  = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    input  logic       start,
    input  logic       idle,
    input  logic       add30,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       timerEnd
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [3:0] MAX_TENS  = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_UNITS = 4'(MAX_MIN % 10);

    typedef enum logic [2:0] {S_IDLE, S_LOADED, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t           state, state_nx;
    logic [DIV_W-1:0] div, div_nx;
    logic [15:0]      val_nx, dec_val, base_val, run_val, load_val;
    logic             tick, load_zero, te_nx;

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [15:0] dec1(input logic [7:0] m, input logic [7:0] s);
        logic [3:0] mt, mu, st, su;
        {mt, mu} = m;
        {st, su} = s;
        if (su != 4'd0) su = su - 4'd1;
        else begin
            su = 4'd9;
            if (st != 4'd0) st = st - 4'd1;
            else begin
                st = 4'd5;
                if (mu != 4'd0) mu = mu - 4'd1;
                else begin
                    mu = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    // Per-digit clamp first, then the minute ceiling and the 59-second ceiling.
    always_comb begin
        load_val = {clamp9(set_min[7:4]), clamp9(set_min[3:0]),
                    clamp9(set_sec[7:4]), clamp9(set_sec[3:0])};
        if (load_val[15:12] > MAX_TENS ||
            (load_val[15:12] == MAX_TENS && load_val[11:8] > MAX_UNITS))
            load_val[15:8] = {MAX_TENS, MAX_UNITS};
        if (load_val[7:4] > 4'd5)
            load_val[7:0] = 8'h59;
    end

    assign load_zero = (load_val == 16'h0000);
    assign tick      = (state == S_RUN) && (div == DIV_LAST);
    assign dec_val   = dec1(min_bcd, sec_bcd);
    assign base_val  = tick ? dec_val : {min_bcd, sec_bcd};

`ifdef MWV_ADD30_EN
    logic [15:0] add_cur;

    function automatic logic [15:0] plus30(input logic [7:0] m, input logic [7:0] s);
        logic [3:0] mt, mu, st;
        logic       carry;
        {mt, mu} = m;
        carry = (s[7:4] >= 4'd3);
        st    = carry ? s[7:4] - 4'd3 : s[7:4] + 4'd3;
        if (!carry) return {m, st, s[3:0]};
        if (m == {MAX_TENS, MAX_UNITS}) return {MAX_TENS, MAX_UNITS, 8'h59};
        if (mu == 4'd9) begin
            mu = 4'd0;
            mt = mt + 4'd1;
        end else begin
            mu = mu + 4'd1;
        end
        return {mt, mu, st, s[3:0]};
    endfunction

    // A coincident tick is applied before the +30 s, giving a net +29 s.
    assign run_val = add30 ? plus30(base_val[15:8], base_val[7:0]) : base_val;
    assign add_cur = plus30(min_bcd, sec_bcd);
`else
    logic unused_add30;
    assign unused_add30 = add30;
    assign run_val      = base_val;
`endif

    always_comb begin
        state_nx = state;
        div_nx   = '0;
        val_nx   = {min_bcd, sec_bcd};
        case (state)
            S_IDLE: begin
                if (load) begin
                    val_nx   = load_val;
                    state_nx = load_zero ? S_IDLE : S_LOADED;
                end
`ifdef MWV_ADD30_EN
                else if (add30) begin
                    val_nx   = 16'h0030;
                    state_nx = S_LOADED;
                end
`endif
            end
            S_LOADED: begin
                if (load) begin
                    val_nx   = load_val;
                    state_nx = load_zero ? S_IDLE : S_LOADED;
                end else begin
`ifdef MWV_ADD30_EN
                    if (add30) val_nx = add_cur;
`endif
                    if (start) state_nx = S_RUN;
                end
            end
            S_RUN: begin
                div_nx = tick ? '0 : div + 1'b1;
                val_nx = run_val;
                if (run_val == 16'h0000) state_nx = S_DONE;
                else if (!start)         state_nx = S_PAUSE;
            end
            S_PAUSE: begin
                if (load) begin
                    val_nx   = load_val;
                    state_nx = load_zero ? S_IDLE : S_LOADED;
                end else begin
                    div_nx = div;
`ifdef MWV_ADD30_EN
                    if (add30) val_nx = add_cur;
`endif
                    if (start) state_nx = S_RUN;
                    else if (idle) begin
                        state_nx = S_IDLE;
                        val_nx   = 16'h0000;
                        div_nx   = '0;
                    end
                end
            end
            S_DONE: begin
                if (load) begin
                    val_nx   = load_val;
                    state_nx = load_zero ? S_IDLE : S_LOADED;
                end
`ifdef MWV_ADD30_EN
                else if (add30) begin
                    val_nx   = 16'h0030;
                    state_nx = S_LOADED;
                end
`endif
                else if (!start && idle) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        // Registered one clk behind entering DONE, but dropped on the exit clk.
        te_nx = (state == S_DONE) && (state_nx == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            div      <= '0;
            min_bcd  <= 8'h00;
            sec_bcd  <= 8'h00;
            timerEnd <= 1'b0;
        end else begin
            state    <= state_nx;
            div      <= div_nx;
            min_bcd  <= val_nx[15:8];
            sec_bcd  <= val_nx[7:0];
            timerEnd <= te_nx;
        end
    end

    assign running = (state == S_RUN);

endmodule
